cadd_rr_arbiter: RTL and testbench



---
 rtl/cadd_rr_arbiter.sv | 108 ++++++++++
 tb/tb_cadd_rr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cadd_rr_arbiter.sv
// cadd_rr_arbiter: round-robin shared complex adder with a single tagged result slot
module cadd_rr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int SATURATE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_real,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_imag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_real,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_imag,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_real,
  output logic [DATA_WIDTH-1:0]          rsp_imag
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic S_EMPTY = 1'b0;
  localparam logic S_FULL  = 1'b1;
  logic                  state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] real_q, real_d, imag_q, imag_d;
  logic [NUM_REQ-1:0]    rot;
  logic [PW-1:0]         off, grant;
  logic [PW:0]           gsum;
  logic                  found, can_accept, accept;
  logic [DATA_WIDTH-1:0] a_r, a_i, b_r, b_i;

  function automatic logic [DATA_WIDTH-1:0] add_c(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    return (SATURATE != 0 && s[DATA_WIDTH] != s[DATA_WIDTH-1])
      ? (s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}})
      : s[DATA_WIDTH-1:0];
  endfunction

  // rotate requests so the search starts at ptr, take the nearest one, map back to an index
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    off = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) begin
        off = PW'(k);
        found = 1'b1;
      end
    gsum = {1'b0, ptr_q} + {1'b0, off};
    grant = (gsum >= (PW+1)'(NUM_REQ)) ? PW'(gsum - (PW+1)'(NUM_REQ)) : PW'(gsum);
  end

  // select the granted requester's operands
  always_comb begin
    a_r = '0;
    a_i = '0;
    b_r = '0;
    b_i = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (grant == PW'(k)) begin
        a_r = req_a_real[k*DATA_WIDTH +: DATA_WIDTH];
        a_i = req_a_imag[k*DATA_WIDTH +: DATA_WIDTH];
        b_r = req_b_real[k*DATA_WIDTH +: DATA_WIDTH];
        b_i = req_b_imag[k*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  // slot register, pointer and result flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      real_q  <= '0;
      imag_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      real_q  <= real_d;
      imag_q  <= imag_d;
    end
  end

  // next slot state: an accept always fills it, a drain without accept empties it
  always_comb begin
    state_d = accept ? S_FULL : (state_q == S_FULL && !rsp_ready) ? S_FULL : S_EMPTY;
    ptr_d   = accept ? ((grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1) : ptr_q;
    id_d    = accept ? ID_WIDTH'(grant) : id_q;
    real_d  = accept ? add_c(a_r, b_r) : real_q;
    imag_d  = accept ? add_c(a_i, b_i) : imag_q;
  end

  // handshake and registered response outputs
  always_comb begin
    can_accept = (state_q == S_EMPTY) || rsp_ready;
    req_ready  = (found && can_accept && !rst) ? (NUM_REQ'(1) << grant) : '0;
    accept     = |req_ready;
    rsp_valid  = (state_q == S_FULL);
    rsp_id     = id_q;
    rsp_real   = real_q;
    rsp_imag   = imag_q;
  end
endmodule

// File: tb/tb_cadd_rr_arbiter.sv
// tb_cadd_rr_arbiter: wrap and saturate instances checked against a queue-free behavioural model
module tb_cadd_rr_arbiter;
  localparam int N = 4, DW = 16, IW = 2;
  logic clk = 1'b0, rst = 1'b1, rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0, rdy_w, rdy_s;
  logic [N*DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic vld_w, vld_s;
  logic [IW-1:0] id_w, id_s;
  logic [DW-1:0] re_w, im_w, re_s, im_s, held;
  int vectors = 0, miscompares = 0;
  bit m_valid;
  int m_id, m_ptr;
  logic [DW-1:0] m_wr, m_wi, m_sr, m_si;

  always #5 clk = ~clk;

  cadd_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(IW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w),
    .req_a_real(a_re), .req_a_imag(a_im), .req_b_real(b_re), .req_b_imag(b_im),
    .rsp_valid(vld_w), .rsp_ready(rsp_ready), .rsp_id(id_w), .rsp_real(re_w), .rsp_imag(im_w));

  cadd_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(IW), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_s),
    .req_a_real(a_re), .req_a_imag(a_im), .req_b_real(b_re), .req_b_imag(b_im),
    .rsp_valid(vld_s), .rsp_ready(rsp_ready), .rsp_id(id_s), .rsp_real(re_s), .rsp_imag(im_s));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkd(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  function automatic int sv(logic [DW-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic [DW-1:0] sat(int s);
    int lim = 1 << (DW - 1);
    return (s > lim - 1) ? DW'(lim - 1) : (s < -lim) ? DW'(-lim) : DW'(s);
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g = pick();
    if (rst || g < 0 || (m_valid && !rsp_ready)) return '0;
    return N'(1) << g;
  endfunction

  task automatic set_op(int i, int ar, int ai, int br, int bi);
    a_re[i*DW +: DW] = DW'(ar);
    a_im[i*DW +: DW] = DW'(ai);
    b_re[i*DW +: DW] = DW'(br);
    b_im[i*DW +: DW] = DW'(bi);
  endtask

  function automatic int rv();
    case ($urandom % 6)
      0: return (1 << (DW - 1)) - 1;
      1: return -(1 << (DW - 1));
      2: return -1;
      default: return int'($urandom % (1 << DW)) - (1 << (DW - 1));
    endcase
  endfunction

  task automatic step();
    int g, sr, si;
    logic [N-1:0] er;
    @(negedge clk);
    g = pick();
    er = exp_ready();
    chk("ready_wrap", 32'(rdy_w), 32'(er));
    chk("ready_sat", 32'(rdy_s), 32'(er));
    chk("valid_wrap", 32'(vld_w), 32'(m_valid));
    chk("valid_sat", 32'(vld_s), 32'(m_valid));
    if (m_valid) begin
      chk("id_wrap", 32'(id_w), m_id);
      chk("id_sat", 32'(id_s), m_id);
      chkd("real_wrap", re_w, m_wr);
      chkd("imag_wrap", im_w, m_wi);
      chkd("real_sat", re_s, m_sr);
      chkd("imag_sat", im_s, m_si);
    end
    if (rst) begin
      m_valid = 1'b0;
      m_id = 0;
      m_ptr = 0;
    end else if (er != '0) begin
      sr = sv(a_re[g*DW +: DW]) + sv(b_re[g*DW +: DW]);
      si = sv(a_im[g*DW +: DW]) + sv(b_im[g*DW +: DW]);
      m_wr = DW'(sr);
      m_wi = DW'(si);
      m_sr = sat(sr);
      m_si = sat(si);
      m_valid = 1'b1;
      m_id = g;
      m_ptr = (g + 1) % N;
    end else if (m_valid && rsp_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_valid = 1'b0;
    m_id = 0;
    m_ptr = 0;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    chk("ready_in_reset", 32'(rdy_w), 0);
    step();
    step();
    chk("rst_valid", 32'(vld_w), 0);
    chk("rst_id", 32'(id_w), 0);
    chkd("rst_real", re_w, '0);
    chkd("rst_imag", im_s, '0);
    rst = 1'b0;
    req_valid = '0;
    step();
    set_op(0, 100, -50, 23, 7);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(rdy_w), 32'h1);
    step();
    chk("single_valid", 32'(vld_w), 1);
    chk("single_id", 32'(id_w), 0);
    chkd("single_real", re_w, DW'(123));
    chkd("single_imag", im_w, DW'(-43));
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      set_op(k % 4, k, 10 * k, 1, 2);
      #1;
      chk("rr_grant", 32'(rdy_w), 32'(1) << (k % 4));
      step();
      chk("rr_id", 32'(id_w), k % 4);
      chk("rr_valid", 32'(vld_w), 1);
    end
    req_valid = 4'b0100;
    step();
    chk("bp_setup_id", 32'(id_w), 2);
    rsp_ready = 1'b0;
    req_valid = 4'b1011;
    held = re_w;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(rdy_w), 0);
      step();
      chk("bp_id", 32'(id_w), 2);
      chkd("bp_hold", re_w, held);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_next3", 32'(rdy_w), 32'h8);
    step();
    chk("bp_id3", 32'(id_w), 3);
    #1;
    chk("bp_next0", 32'(rdy_w), 32'h1);
    step();
    chk("bp_id0", 32'(id_w), 0);
    set_op(0, 32767, -32768, 1, -1);
    req_valid = 4'b0001;
    step();
    chkd("wrap_real", re_w, DW'(-32768));
    chkd("wrap_imag", im_w, DW'(32767));
    chkd("sat_real", re_s, DW'(32767));
    chkd("sat_imag", im_s, DW'(-32768));
    req_valid = 4'b0100;
    step();
    chk("drain_accept_valid", 32'(vld_w), 1);
    chk("drain_accept_id", 32'(id_w), 2);
    req_valid = '1;
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(rdy_w), 0);
    step();
    chk("midrst_valid", 32'(vld_w), 0);
    chk("midrst_id", 32'(id_s), 0);
    chkd("midrst_real", re_s, '0);
    chkd("midrst_imag", im_w, '0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("midrst_first", 32'(rdy_w), 32'h1);
    step();
    chk("midrst_first_id", 32'(id_w), 0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 300) == 0;
      req_valid = N'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) set_op(i, rv(), rv(), rv(), rv());
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
